// File: rtl/clock_pkg.sv
// Shared definitions for the timekeeper UI sequencer: mode encoding, BCD limits
// and field-select values.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_T_HOUR = 3'd1,
        ST_T_MIN  = 3'd2,
        ST_A_HOUR = 3'd3,
        ST_A_MIN  = 3'd4
    } state_t;

    localparam logic [7:0] HOUR_MIN  = 8'h01;
    localparam logic [7:0] HOUR_MAX  = 8'h12;
    localparam logic [7:0] MIN_MAX   = 8'h59;
    localparam logic [3:0] DIGIT_MAX = 4'h9;

    localparam logic FIELD_HOUR = 1'b0;
    localparam logic FIELD_MIN  = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for an active-low pushbutton;
// emits a one-cycle press pulse on each accepted press, nothing on release.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // Any sample equal to the accepted level restarts the stability count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Button-driven mode sequencer for the 12-hour BCD timekeeper; writes only
// range-checked BCD values with a one-cycle active-low SET strobe.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_MODE,
    input  logic       BTN_SET,
    input  logic [7:0] SW_IN,
    output logic       TS_STATE,
    output logic       AS_STATE,
    output logic       SWITCH,
    output logic       SET,
    output logic [7:0] SW_OUT,
    output logic       ERR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic          commit_q, commit_d;
    logic          set_n_q, set_n_d;
    logic [7:0]    sw_out_q, sw_out_d;
    logic          err_q, err_d;
    logic          ts_q, ts_d;
    logic          as_q, as_d;
    logic          switch_q, switch_d;
    logic [TW-1:0] timer_q, timer_d;

    logic mode_press, set_press;
    logic field_sel, hour_ok, min_ok, entry_ok, in_edit;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (CLK),
        .rst   (RST),
        .btn_n (BTN_MODE),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk   (CLK),
        .rst   (RST),
        .btn_n (BTN_SET),
        .press (set_press)
    );

    // Ones digit must be decimal; the range compares then cover the tens digit.
    assign hour_ok   = (SW_IN[3:0] <= DIGIT_MAX) && (SW_IN >= HOUR_MIN) && (SW_IN <= HOUR_MAX);
    assign min_ok    = (SW_IN[3:0] <= DIGIT_MAX) && (SW_IN <= MIN_MAX);
    assign field_sel = (state_q == ST_T_MIN || state_q == ST_A_MIN) ? FIELD_MIN : FIELD_HOUR;
    assign entry_ok  = (field_sel == FIELD_MIN) ? min_ok : hour_ok;
    assign in_edit   = (state_q != ST_RUN);

    always_comb begin
        state_d  = state_q;
        commit_d = 1'b0;
        set_n_d  = 1'b1;
        sw_out_d = sw_out_q;
        err_d    = err_q;
        timer_d  = timer_q;
        if (commit_q) begin
            // Strobe cycle: presses are dropped, state advances as SET rises.
            timer_d = '0;
            case (state_q)
                ST_T_HOUR: state_d = ST_T_MIN;
                ST_A_HOUR: state_d = ST_A_MIN;
                default:   state_d = ST_RUN;
            endcase
        end else if (mode_press) begin
            err_d   = 1'b0;
            timer_d = '0;
            case (state_q)
                ST_RUN:              state_d = ST_T_HOUR;
                ST_T_HOUR, ST_T_MIN: state_d = ST_A_HOUR;
                default:             state_d = ST_RUN;
            endcase
        end else if (set_press) begin
            err_d   = 1'b0;
            timer_d = '0;
            if (in_edit) begin
                if (entry_ok) begin
                    sw_out_d = SW_IN;
                    set_n_d  = 1'b0;
                    commit_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (in_edit) begin
            if (timer_q == TMR_LAST) begin
                state_d = ST_RUN;
                err_d   = 1'b0;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
        ts_d     = (state_d == ST_T_HOUR) || (state_d == ST_T_MIN);
        as_d     = (state_d == ST_A_HOUR) || (state_d == ST_A_MIN);
        switch_d = (state_d == ST_T_MIN) || (state_d == ST_A_MIN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_RUN;
            commit_q <= 1'b0;
            set_n_q  <= 1'b1;
            sw_out_q <= 8'h00;
            err_q    <= 1'b0;
            ts_q     <= 1'b0;
            as_q     <= 1'b0;
            switch_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            commit_q <= commit_d;
            set_n_q  <= set_n_d;
            sw_out_q <= sw_out_d;
            err_q    <= err_d;
            ts_q     <= ts_d;
            as_q     <= as_d;
            switch_q <= switch_d;
            timer_q  <= timer_d;
        end
    end

    assign TS_STATE = ts_q;
    assign AS_STATE = as_q;
    assign SWITCH   = switch_q;
    assign SET      = set_n_q;
    assign SW_OUT   = sw_out_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with short debounce and timeout settings.
module tb_clock_mode_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       BTN_MODE;
    logic       BTN_SET;
    logic [7:0] SW_IN;
    logic       TS_STATE, AS_STATE, SWITCH, SET, ERR;
    logic [7:0] SW_OUT;

    int errors = 0;
    int checks = 0;

    int         pulses = 0;
    int         double_low = 0;
    logic       prev_low = 1'b0;
    logic [7:0] cap_sw = 8'h00;
    logic       cap_ts = 1'b0;
    logic       cap_as = 1'b0;
    logic       cap_switch = 1'b0;

    clock_mode_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_MODE (BTN_MODE),
        .BTN_SET  (BTN_SET),
        .SW_IN    (SW_IN),
        .TS_STATE (TS_STATE),
        .AS_STATE (AS_STATE),
        .SWITCH   (SWITCH),
        .SET      (SET),
        .SW_OUT   (SW_OUT),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    // Strobe monitor: records every SET-low cycle and what was presented with it.
    always @(posedge CLK) begin
        #1;
        if (SET === 1'b0) begin
            pulses     = pulses + 1;
            cap_sw     = SW_OUT;
            cap_ts     = TS_STATE;
            cap_as     = AS_STATE;
            cap_switch = SWITCH;
            if (prev_low) double_low = double_low + 1;
        end
        prev_low = (SET === 1'b0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input bit is_set);
        if (is_set) BTN_SET = 1'b0; else BTN_MODE = 1'b0;
        tick(10);
        BTN_SET  = 1'b1;
        BTN_MODE = 1'b1;
        tick(10);
    endtask

    task automatic set_entry(input logic [7:0] v);
        SW_IN = v;
        tick(1);
        press(1'b1);
    endtask

    initial begin
        int  p0;
        bit  seen;
        RST = 1'b1; BTN_MODE = 1'b1; BTN_SET = 1'b1; SW_IN = 8'h00;
        tick(5);
        RST = 1'b0;
        tick(100);
        check("rst_ts", TS_STATE, 1'b0);
        check("rst_as", AS_STATE, 1'b0);
        check("rst_switch", SWITCH, 1'b0);
        check("rst_set", SET, 1'b1);
        check("rst_sw_out", SW_OUT, 8'h00);
        check("rst_err", ERR, 1'b0);
        check("rst_no_pulse", pulses, 0);

        // Time-set path: hour 11 then minute 45.
        press(1'b0);
        check("thour_ts", TS_STATE, 1'b1);
        check("thour_switch", SWITCH, 1'b0);
        set_entry(8'h11);
        check("h11_pulses", pulses, 1);
        check("h11_cap_sw", cap_sw, 8'h11);
        check("h11_cap_ts", cap_ts, 1'b1);
        check("h11_cap_switch", cap_switch, 1'b0);
        check("tmin_switch", SWITCH, 1'b1);
        SW_IN = 8'h45;
        tick(3);
        check("sw_out_held", SW_OUT, 8'h11);
        press(1'b1);
        check("m45_pulses", pulses, 2);
        check("m45_cap_sw", cap_sw, 8'h45);
        check("m45_cap_switch", cap_switch, 1'b1);
        check("m45_run_ts", TS_STATE, 1'b0);
        check("m45_run_switch", SWITCH, 1'b0);

        // Hour range rejection.
        press(1'b0);
        set_entry(8'h13);
        check("h13_err", ERR, 1'b1);
        check("h13_ts", TS_STATE, 1'b1);
        set_entry(8'h00);
        check("h00_err", ERR, 1'b1);
        set_entry(8'h1A);
        check("h1a_err", ERR, 1'b1);
        check("h1a_switch", SWITCH, 1'b0);
        check("bad_hour_no_pulse", pulses, 2);
        set_entry(8'h12);
        check("h12_err", ERR, 1'b0);
        check("h12_pulses", pulses, 3);
        check("h12_cap_sw", cap_sw, 8'h12);

        // Alarm path from T_MIN: hour 07, bad minute 60, minute 30.
        press(1'b0);
        check("ahour_as", AS_STATE, 1'b1);
        check("ahour_ts", TS_STATE, 1'b0);
        set_entry(8'h07);
        check("a07_cap_sw", cap_sw, 8'h07);
        check("amin_switch", SWITCH, 1'b1);
        set_entry(8'h60);
        check("m60_err", ERR, 1'b1);
        check("m60_no_pulse", pulses, 4);
        set_entry(8'h30);
        check("m30_pulses", pulses, 5);
        check("m30_cap_sw", cap_sw, 8'h30);
        check("m30_cap_as", cap_as, 1'b1);
        check("m30_cap_switch", cap_switch, 1'b1);
        check("m30_run_as", AS_STATE, 1'b0);
        check("m30_err", ERR, 1'b0);

        // Glitch shorter than the debounce window, in T_HOUR with a valid value.
        press(1'b0);
        SW_IN = 8'h05;
        BTN_SET = 1'b0;
        tick(3);
        BTN_SET = 1'b1;
        tick(20);
        check("glitch_no_pulse", pulses, 5);
        check("glitch_ts", TS_STATE, 1'b1);
        check("glitch_switch", SWITCH, 1'b0);

        // Coincident presses: MODE wins, SET dropped.
        BTN_MODE = 1'b0;
        BTN_SET  = 1'b0;
        tick(10);
        BTN_MODE = 1'b1;
        BTN_SET  = 1'b1;
        tick(10);
        check("both_as", AS_STATE, 1'b1);
        check("both_ts", TS_STATE, 1'b0);
        check("both_no_pulse", pulses, 5);

        // Idle timeout from T_HOUR.
        press(1'b0);
        check("to_run_first", TS_STATE, 1'b0);
        press(1'b0);
        tick(30);
        check("to_still_edit", TS_STATE, 1'b1);
        tick(40);
        check("to_back_run", TS_STATE, 1'b0);
        check("to_no_pulse", pulses, 5);

        // Reset landing on the strobe cycle.
        press(1'b0);
        SW_IN = 8'h03;
        tick(1);
        BTN_SET = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick(1);
            if (SET === 1'b0) seen = 1'b1;
        end
        check("rstc_strobe_seen", seen, 1'b1);
        RST = 1'b1;
        tick(1);
        check("rstc_set", SET, 1'b1);
        check("rstc_ts", TS_STATE, 1'b0);
        check("rstc_sw_out", SW_OUT, 8'h00);
        RST = 1'b0;
        BTN_SET = 1'b1;
        p0 = pulses;
        tick(20);
        check("rstc_no_second", pulses - p0, 0);
        check("rstc_still_run", TS_STATE, 1'b0);
        check("single_cycle_strobe", double_low, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
